// File: rtl/pmem_pkg.sv
// Shared types and constants for the paged program-memory controller.
package pmem_pkg;

    localparam int unsigned PC_LEN     = 8;
    localparam int unsigned INSTR_LEN  = 12;
    localparam int unsigned PAGE_BITS  = 2;
    localparam int unsigned NUM_PAGES  = 2 ** PAGE_BITS;
    localparam int unsigned PAGE_WORDS = 2 ** PC_LEN;
    localparam int unsigned ADDR_LEN   = PAGE_BITS + PC_LEN;
    localparam int unsigned MEM_WORDS  = 2 ** ADDR_LEN;

    typedef logic [INSTR_LEN-1:0] instr_t;
    typedef logic [PC_LEN-1:0]    pc_t;
    typedef logic [PAGE_BITS-1:0] page_t;
    typedef logic [ADDR_LEN-1:0]  addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } pmem_state_e;

    localparam instr_t NOP_INSTR = INSTR_LEN'(0);
    localparam pc_t    LAST_PC   = PC_LEN'(PAGE_WORDS - 1);

    // Flat array address: page in the upper bits, word offset below.
    function automatic addr_t mk_addr(input page_t page, input pc_t pc);
        return {page, pc};
    endfunction

endpackage

// File: rtl/pmem_ctrl_if.sv
// Host load channel plus core fetch/page-switch channel of the program memory.
interface pmem_ctrl_if;
    import pmem_pkg::*;

    logic   LD_START;
    page_t  LD_PAGE;
    logic   LD_VALID;
    instr_t LD_DATA;
    logic   LD_LAST;
    logic   LD_READY;
    logic   LD_DONE;
    logic   RUN_START;
    logic   HALT;
    pc_t    PC;
    logic   PG_WE;
    page_t  PG_SEL;
    instr_t INSTR;
    logic   CORE_RUN;
    page_t  ACT_PAGE;

    modport slave (
        input  LD_START, LD_PAGE, LD_VALID, LD_DATA, LD_LAST,
        input  RUN_START, HALT, PC, PG_WE, PG_SEL,
        output LD_READY, LD_DONE, INSTR, CORE_RUN, ACT_PAGE
    );

    modport master (
        output LD_START, LD_PAGE, LD_VALID, LD_DATA, LD_LAST,
        output RUN_START, HALT, PC, PG_WE, PG_SEL,
        input  LD_READY, LD_DONE, INSTR, CORE_RUN, ACT_PAGE
    );

endinterface

// File: rtl/pmem_array.sv
// Single-write, registered-read instruction RAM; read register idles at NOP.
module pmem_array
    import pmem_pkg::*;
(
    input  logic   CLK,
    input  logic   RST,
    input  logic   we,
    input  addr_t  waddr,
    input  instr_t wdata,
    input  logic   re,
    input  addr_t  raddr,
    output instr_t rdata
);

    instr_t mem [MEM_WORDS];

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register doubles as the core INSTR register, so it shows NOP unless fetching.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata <= NOP_INSTR;
        end else if (re) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/pmem_ctrl.sv
// Paged program-memory controller: host page loader and core instruction server.
module pmem_ctrl
    import pmem_pkg::*;
(
    input  logic      CLK,
    input  logic      RST,
    pmem_ctrl_if.slave bus
);

    pmem_state_e state;
    pmem_state_e state_nxt;

    pc_t    ld_addr;
    pc_t    ld_addr_nxt;
    page_t  ld_page;
    page_t  ld_page_nxt;
    page_t  act_page_q;
    page_t  act_page_nxt;
    logic   ld_ready_q;
    logic   ld_ready_nxt;
    logic   ld_done_q;
    logic   ld_done_nxt;
    logic   core_run_q;
    logic   core_run_nxt;
    logic   mem_we;
    logic   mem_re;
    logic   accept_c;
    logic   load_end_c;
    instr_t rd_data;

    assign accept_c   = ld_ready_q && bus.LD_VALID;
    assign load_end_c = accept_c && (bus.LD_LAST || (ld_addr == LAST_PC));

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; LD_START outranks RUN_START in IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.LD_START) begin
                    state_nxt = LOAD;
                end else if (bus.RUN_START) begin
                    state_nxt = RUN;
                end
            end
            LOAD: begin
                if (load_end_c) begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (bus.HALT) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output/datapath decode: next values of the registered outputs and RAM strobes.
    always_comb begin
        ld_addr_nxt  = ld_addr;
        ld_page_nxt  = ld_page;
        act_page_nxt = act_page_q;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        ld_ready_nxt = (state_nxt == LOAD);
        core_run_nxt = (state_nxt == RUN);
        ld_done_nxt  = (state == LOAD) && (state_nxt == IDLE);
        unique case (state)
            IDLE: begin
                if (bus.LD_START) begin
                    ld_page_nxt = bus.LD_PAGE;
                    ld_addr_nxt = PC_LEN'(0);
                end else if (bus.RUN_START) begin
                    act_page_nxt = PAGE_BITS'(0);
                end
            end
            LOAD: begin
                mem_we = accept_c;
                if (accept_c) begin
                    ld_addr_nxt = ld_addr + PC_LEN'(1);
                end
            end
            RUN: begin
                mem_re = (state_nxt == RUN);
                if (bus.PG_WE) begin
                    act_page_nxt = bus.PG_SEL;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs, load cursor and active page.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ld_addr    <= PC_LEN'(0);
            ld_page    <= PAGE_BITS'(0);
            act_page_q <= PAGE_BITS'(0);
            ld_ready_q <= 1'b0;
            ld_done_q  <= 1'b0;
            core_run_q <= 1'b0;
        end else begin
            ld_addr    <= ld_addr_nxt;
            ld_page    <= ld_page_nxt;
            act_page_q <= act_page_nxt;
            ld_ready_q <= ld_ready_nxt;
            ld_done_q  <= ld_done_nxt;
            core_run_q <= core_run_nxt;
        end
    end

    pmem_array u_array (
        .CLK   (CLK),
        .RST   (RST),
        .we    (mem_we),
        .waddr (mk_addr(ld_page, ld_addr)),
        .wdata (bus.LD_DATA),
        .re    (mem_re),
        .raddr (mk_addr(act_page_q, bus.PC)),
        .rdata (rd_data)
    );

    assign bus.LD_READY = ld_ready_q;
    assign bus.LD_DONE  = ld_done_q;
    assign bus.CORE_RUN = core_run_q;
    assign bus.ACT_PAGE = act_page_q;
    assign bus.INSTR    = rd_data;

endmodule

// File: doc/pmem_ctrl.md
Name: pmem_ctrl

Overview:
- Synthesizable program-memory controller for the 8bit-simple core. It is the hardware counterpart of the bench's page-based instruction store.
- Load side: an external host streams instruction words into a selected page over a valid/ready interface.
- Run side: the block serves INSTR for the core's PC out of the current page. The core can switch pages at run time.
- Sits between the host/programmer interface and the core's INSTR/PC ports.

Parameters:
- PC_LEN, 8, width of the core PC; words per page = 2**PC_LEN.
- INSTR_LEN, 12, instruction word width.
- PAGE_BITS, 2, page-select width; NUM_PAGES = 2**PAGE_BITS.
- NOP_INSTR, 0, value driven on INSTR whenever the core is not running.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- LD_START  in  1  pulse: begin loading the page given on LD_PAGE.
- LD_PAGE  in  PAGE_BITS  target page, sampled with LD_START.
- LD_VALID  in  1  host word valid.
- LD_DATA  in  INSTR_LEN  host instruction word.
- LD_LAST  in  1  marks the final word of a load; qualified by LD_VALID.
- LD_READY  out  1  controller accepts a word this cycle.
- LD_DONE  out  1  one-cycle pulse when a load completes.
- RUN_START  in  1  pulse: release the core and start serving instructions.
- HALT  in  1  pulse: stop serving and return to IDLE.
- PC  in  PC_LEN  core program counter.
- PG_WE  in  1  core request to switch the active page.
- PG_SEL  in  PAGE_BITS  requested page, sampled with PG_WE.
- INSTR  out  INSTR_LEN  registered instruction to the core.
- CORE_RUN  out  1  high while in RUN; drives the core's reset release.
- ACT_PAGE  out  PAGE_BITS  currently active run page.

Behaviour:
- Reset (asynchronous, RST high): state=IDLE, INSTR=NOP_INSTR, LD_READY=0, LD_DONE=0, CORE_RUN=0, ACT_PAGE=0, load address=0.
- Memory array is not reset. Contents survive RST.
- States are IDLE, LOAD, RUN.
- IDLE:
  - LD_START goes to LOAD. Latches LD_PAGE; address=0.
  - Else RUN_START goes to RUN. ACT_PAGE=0; CORE_RUN=1 from the next cycle.
  - LD_START and RUN_START in the same cycle: LD_START wins; RUN_START is dropped.
- LOAD:
  - LD_READY=1 throughout.
  - Each cycle with LD_VALID&&LD_READY writes LD_DATA to mem[page][addr], then addr+1.
  - Load ends when the accepted word has LD_LAST=1, or when addr==2**PC_LEN-1 is written. The page is then full and does not wrap.
  - On end: next state IDLE, LD_READY=0, LD_DONE=1 for exactly one cycle.
  - LD_START, RUN_START and HALT are ignored in LOAD.
- RUN:
  - INSTR <= mem[ACT_PAGE][PC] every posedge, so INSTR shows the word for the PC sampled at the previous edge (1-cycle latency).
  - PG_WE: ACT_PAGE <= PG_SEL at that edge. The fetch in the same edge still uses the old page; the new page applies from the next fetch.
  - HALT: next state IDLE, CORE_RUN=0, INSTR=NOP_INSTR at that edge.
  - HALT with PG_WE in the same cycle: HALT wins; ACT_PAGE still updates.
  - LD_* inputs are ignored and LD_READY stays 0.
- Reset mid-load: words already written are retained, the load aborts, and no LD_DONE is issued.
- Reset mid-run: CORE_RUN drops asynchronously.
- Reads of never-loaded words return X in simulation. The bench must load before it runs.

Decomposition:
- Shared package pmem_pkg:
  - typedef pmem_state_e {IDLE, LOAD, RUN};
  - typedefs for instr_t, pc_t and page_t;
  - constant NOP_INSTR.
- Sub-module pmem_array: a 2**(PAGE_BITS+PC_LEN) x INSTR_LEN synchronous RAM.
  - One write port and one registered read port.
  - Address = {page, pc}.
- The FSM, load counter and page register stay in pmem_ctrl.

Test Plan:
- Reset check: assert RST with the clock running; outputs are INSTR=0, CORE_RUN=0, LD_READY=0, ACT_PAGE=0. Deassert RST; state stays IDLE with no spurious LD_DONE.
- Short load, then run: LD_START with LD_PAGE=1, then words 12'hA01, 12'hA02 and 12'hA03 (LAST on the third). LD_DONE pulses once, on the cycle after the third accept. Then HALT; load page 0 with 12'h111 and 12'h222; RUN_START. With PC=0 then 1, INSTR is 12'h111 then 12'h222, each one cycle after its PC.
- Full-page load: stream 256 words (value = index) into page 2 with no LAST. LD_DONE follows word 255, and LD_READY drops. A 257th word held on LD_VALID is not written, so page-3 address 0 is unchanged.
- Page switch: in RUN with PC=0, pulse PG_WE with PG_SEL=1. The fetch at that edge returns 12'h111 (page 0); the next fetch returns 12'hA01 (page 1). ACT_PAGE=1.
- Backpressure and priority: toggle LD_VALID every other cycle during a load; only valid cycles advance the address. LD_START and RUN_START together in IDLE enter LOAD, and CORE_RUN stays 0.
- Reset mid-load: RST after 2 of 4 words. No LD_DONE is issued. A later run reads those 2 words intact.
